// File: rtl/legv8_pkg.sv
// ============================================================================
// Module : legv8_pkg
// Brief  : Shared types and constants for the LEGv8 instruction-fetch front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package legv8_pkg;

    localparam logic [31:0] INSTR_NOP       = 32'h0000_0000;
    localparam int          PC_W_DEFAULT    = 64;
    localparam int          INSTR_W_DEFAULT = 32;
    localparam int          PC_INC          = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/legv8_fetch_queue_if.sv
// ============================================================================
// Module : legv8_fetch_queue_if
// Brief  : Instruction-memory, redirect and decode-side signals of the fetch queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface legv8_fetch_queue_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               id_ready;
    logic               id_valid;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;

    // Fetch unit view.
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect, redirect_pc, id_ready
    );

    // Memory / pipeline view.
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect, redirect_pc, id_ready
    );
endinterface

`default_nettype wire

// File: rtl/legv8_fwft_fifo.sv
// ============================================================================
// Module : legv8_fwft_fifo
// Brief  : First-word-fall-through circular buffer of {pc, instr} with clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module legv8_fwft_fifo #(
    parameter  int DEPTH   = 4,
    parameter  int PC_W    = 64,
    parameter  int INSTR_W = 32,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               push_i,
    input  wire logic [PC_W-1:0]    push_pc_i,
    input  wire logic [INSTR_W-1:0] push_instr_i,
    input  wire logic               pop_i,
    input  wire logic               clear_i,
    output logic [CNT_W-1:0]        count_o,
    output logic                    valid_o,
    output logic [PC_W-1:0]         head_pc_o,
    output logic [INSTR_W-1:0]      head_instr_o
);

    logic [PC_W-1:0]    mem_pc_q    [DEPTH];
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];
    logic [PTR_W-1:0]   rd_q, wr_q;
    logic [CNT_W-1:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PTR_W'(1);
            if (pop_i)  rd_q <= rd_q + PTR_W'(1);
            count_q <= count_q + {{(CNT_W-1){1'b0}}, push_i}
                               - {{(CNT_W-1){1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_pc_q[wr_q]    <= push_pc_i;
            mem_instr_q[wr_q] <= push_instr_i;
        end
    end

    assign count_o      = count_q;
    assign valid_o      = (count_q != '0);
    assign head_pc_o    = mem_pc_q[rd_q];
    assign head_instr_o = mem_instr_q[rd_q];

endmodule

`default_nettype wire

// File: rtl/legv8_fetch_queue.sv
// ============================================================================
// Module : legv8_fetch_queue
// Brief  : LEGv8 fetch front end: PC, credit-limited imem requests, FWFT queue,
//          redirect flush. Optional perf counters under FETCH_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module legv8_fetch_queue
    import legv8_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input wire logic            clk,
    input wire logic            reset,
    legv8_fetch_queue_if.master fq
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_starve_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_valid;
    logic               fifo_push, fifo_pop, fifo_clear;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;

    logic [CNT_W:0]     credit_sum;
    logic               req_valid, req_fire, rsp;

    // Outstanding requests plus queued words never exceed DEPTH, so every
    // response always has a free slot.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign req_valid  = !reset && !fq.redirect && (credit_sum < (CNT_W+1)'(DEPTH));
    assign req_fire   = req_valid && fq.imem_req_ready;
    assign rsp        = fq.imem_rsp_valid;

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        state_d    = state_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;
        inflight_d = inflight_q + {{(CNT_W-1){1'b0}}, req_fire}
                                - {{(CNT_W-1){1'b0}}, rsp};
        if (req_fire) pc_d = pc_q + PC_W'(PC_INC);

        if (fq.redirect) begin
            // Everything still in flight, minus a word landing right now, is stale.
            pc_d       = fq.redirect_pc;
            fifo_clear = 1'b1;
            drop_d     = inflight_q - {{(CNT_W-1){1'b0}}, rsp};
            state_d    = (drop_d != '0) ? FLUSH : RUN;
        end else begin
            fifo_pop = fifo_valid && fq.id_ready;
            case (state_q)
                RUN: begin
                    fifo_push = rsp;
                end
                FLUSH: begin
                    if (rsp) begin
                        drop_d = drop_q - CNT_W'(1);
                        if (drop_d == '0) state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    legv8_fwft_fifo #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (fifo_push),
        .push_pc_i    (pc_q_for_rsp()),
        .push_instr_i (fq.imem_rsp_data),
        .pop_i        (fifo_pop),
        .clear_i      (fifo_clear),
        .count_o      (fifo_count),
        .valid_o      (fifo_valid),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    // Responses return in request order, so the PC of the word arriving now is
    // the PC of the oldest outstanding request: current pc minus 4*inflight.
    function automatic logic [PC_W-1:0] pc_q_for_rsp();
        return pc_q - (PC_W'(inflight_q) << 2);
    endfunction

    assign fq.imem_req_valid = req_valid;
    assign fq.imem_req_addr  = pc_q;
    assign fq.id_valid       = fifo_valid;
    assign fq.id_pc          = fifo_valid ? head_pc : '0;
    assign fq.id_instr       = fifo_valid ? head_instr : INSTR_W'(INSTR_NOP);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] starve_q, flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            flush_q  <= '0;
        end else begin
            if (fq.id_ready && !fifo_valid && !fq.redirect && (starve_q != '1))
                starve_q <= starve_q + 32'd1;
            if (fq.redirect && (flush_q != '1))
                flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_starve_cnt = starve_q;
    assign perf_flush_cnt  = flush_q;
`endif

endmodule

`default_nettype wire
